// File: rtl/regfile_port_sequencer.sv
// Sequences one register-transfer request: serial operand reads through the single-port
// register file, ALU handshake, then writeback. Optional macro: OPSEQ_SAME_SRC_BYPASS_EN.
module regfile_port_sequencer #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_src_a,
    input  logic [AW-1:0] req_src_b,
    input  logic [AW-1:0] req_dst,
    input  logic          req_wb,
    output logic [DW-1:0] op_a,
    output logic [DW-1:0] op_b,
    output logic          ops_valid,
    input  logic          result_valid,
    input  logic [DW-1:0] result_data,
    output logic          rf_write_en,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_data_in,
    input  logic [DW-1:0] rf_data_out,
    output logic          done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_B,
        S_CAP_B,
        S_EXEC,
        S_WB
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_src_a;
    logic [AW-1:0] r_src_b;
    logic [AW-1:0] r_dst;
    logic          r_wb;
    logic [DW-1:0] r_op_a;
    logic [DW-1:0] r_op_b;
    logic [DW-1:0] r_result;

`ifdef OPSEQ_SAME_SRC_BYPASS_EN
    logic w_same_src;
    assign w_same_src = (r_src_a == r_src_b);
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // NOTE: w_next defaults to the current state first, so no path through the case can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = S_RD_A;
            S_RD_A:  w_next = S_RD_B;
`ifdef OPSEQ_SAME_SRC_BYPASS_EN
            S_RD_B:  w_next = w_same_src ? S_EXEC : S_CAP_B;
`else
            S_RD_B:  w_next = S_CAP_B;
`endif
            S_CAP_B: w_next = S_EXEC;
            S_EXEC:  if (result_valid) w_next = S_WB;
            S_WB:    w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // rf_data_out is registered by the file, so each capture lags its address by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_src_a  <= '0;
            r_src_b  <= '0;
            r_dst    <= '0;
            r_wb     <= 1'b0;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_src_a <= req_src_a;
                    r_src_b <= req_src_b;
                    r_dst   <= req_dst;
                    r_wb    <= req_wb;
                end
                S_RD_B: begin
                    r_op_a <= rf_data_out;
`ifdef OPSEQ_SAME_SRC_BYPASS_EN
                    if (w_same_src) r_op_b <= rf_data_out;
`endif
                end
                S_CAP_B: r_op_b <= rf_data_out;
                // Latching only on result_valid keeps an undriven result bus out of the datapath.
                S_EXEC:  if (result_valid) r_result <= result_data;
                default: ;
            endcase
        end
    end

    // Outputs decode state and latched fields only; no input reaches an output combinationally.
    always_comb begin
        req_ready   = 1'b0;
        ops_valid   = 1'b0;
        rf_write_en = 1'b0;
        rf_addr     = '0;
        rf_data_in  = '0;
        done        = 1'b0;
        case (r_state)
            S_IDLE:  req_ready = 1'b1;
            S_RD_A:  rf_addr = r_src_a;
            S_RD_B:  rf_addr = r_src_b;
            S_CAP_B: rf_addr = r_src_b;
            S_EXEC: begin
                ops_valid = 1'b1;
                rf_addr   = r_dst;
            end
            S_WB: begin
                rf_addr     = r_dst;
                rf_data_in  = r_result;
                rf_write_en = r_wb;
                done        = 1'b1;
            end
            default: ;
        endcase
    end

    assign op_a = r_op_a;
    assign op_b = r_op_b;

endmodule
